// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin front end that shares one external compare_gt
// unit between two requesters, deriving GT/LT/GE/LE in one pass and EQ/NE in two.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester request handshake (ready only in IDLE)
//   req_data1/req_data2         per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   req_is_signed, req_op       per-requester signedness and 3-bit op code
//   resp_valid/resp_ready       per-requester response handshake
//   resp_result                 boolean compare result
//   cmp_data1/cmp_data2         registered operands to the shared compare_gt
//   cmp_is_signed, cmp_result   compare_gt signedness and its data1 > data2 answer
module compare_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data1,
    input  logic [NREQ*WIDTH-1:0] req_data2,
    input  logic [NREQ-1:0]       req_is_signed,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic                  resp_result,
    output logic [WIDTH-1:0]      cmp_data1,
    output logic [WIDTH-1:0]      cmp_data2,
    output logic                  cmp_is_signed,
    input  logic                  cmp_result
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
    state_t state, state_nx;
    logic ptr, gnt_id, grant, swap, done, two_pass;
    logic id_q, gt_q, res_q, rv_q;
    logic [2:0] op_q, gnt_op;

    // preferred requester wins if it asks, otherwise the other one
    assign gnt_id   = req_valid[ptr] ? ptr : ~ptr;
    assign grant    = (state == IDLE) && (|req_valid);
    assign gnt_op   = req_op[int'(gnt_id)*3 +: 3];
    // LT and GE are evaluated as b > a
    assign swap     = (gnt_op == 3'b001) || (gnt_op == 3'b010);
    assign two_pass = (op_q == 3'b100) || (op_q == 3'b101);
    assign done     = rv_q && resp_ready[id_q];
    assign resp_result = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = grant ? PASS1 : IDLE;
            PASS1: state_nx = two_pass ? PASS2 : RESP;
            PASS2: state_nx = RESP;
            RESP:  state_nx = done ? IDLE : RESP;
        endcase
    end

    always_comb begin
        req_ready  = grant ? (NREQ'(1) << gnt_id) : '0;
        resp_valid = rv_q ? (NREQ'(1) << id_q) : '0;
    end

    // cmp_* are the latched operands themselves, so compare_gt only ever
    // sees registered values; resp_valid rises one cycle after entering RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= 1'b0;
            id_q          <= 1'b0;
            op_q          <= 3'b0;
            gt_q          <= 1'b0;
            res_q         <= 1'b0;
            rv_q          <= 1'b0;
            cmp_data1     <= '0;
            cmp_data2     <= '0;
            cmp_is_signed <= 1'b0;
        end else begin
            rv_q <= (state == RESP) && !done;
            if (grant) begin
                ptr           <= ~gnt_id;
                id_q          <= gnt_id;
                op_q          <= gnt_op;
                cmp_is_signed <= req_is_signed[gnt_id];
                cmp_data1     <= swap ? req_data2[int'(gnt_id)*WIDTH +: WIDTH]
                                      : req_data1[int'(gnt_id)*WIDTH +: WIDTH];
                cmp_data2     <= swap ? req_data1[int'(gnt_id)*WIDTH +: WIDTH]
                                      : req_data2[int'(gnt_id)*WIDTH +: WIDTH];
            end
            if (state == PASS1) begin
                // reserved 11x ops fall through with result 0
                res_q <= op_q[2] ? 1'b0 : (op_q[1] ? !cmp_result : cmp_result);
                gt_q  <= cmp_result;
                if (two_pass) begin
                    cmp_data1 <= cmp_data2;
                    cmp_data2 <= cmp_data1;
                end
            end
            if (state == PASS2)
                res_q <= op_q[0] ? (gt_q | cmp_result) : !(gt_q | cmp_result);
        end
    end
endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed scoreboard bench for compare_arbiter with a behavioural compare_gt.
module tb_compare_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_data1 = '0;
    logic [63:0] req_data2 = '0;
    logic [1:0]  req_is_signed = '0;
    logic [5:0]  req_op = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b11;
    logic        resp_result;
    logic [31:0] cmp_data1, cmp_data2;
    logic        cmp_is_signed, cmp_result;

    typedef struct {int id; logic res; int cyc;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen = 0;

    compare_arbiter #(.WIDTH(32), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2),
        .req_is_signed(req_is_signed), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .cmp_data1(cmp_data1), .cmp_data2(cmp_data2),
        .cmp_is_signed(cmp_is_signed), .cmp_result(cmp_result)
    );

    assign cmp_result = cmp_is_signed ? ($signed(cmp_data1) > $signed(cmp_data2))
                                      : (cmp_data1 > cmp_data2);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) seen = 0;
        else begin
            if (resp_valid != 2'b00 && !seen) begin
                seen = 1;
                if (q.size() == 0) chk("unexpected_resp_valid", resp_valid, 0);
                else if (q[0].cyc >= 0) chk("resp_latency", cyc, q[0].cyc);
            end
            if ((resp_valid & resp_ready) != 2'b00) begin
                if (q.size() == 0) chk("unexpected_handshake", resp_valid, 0);
                else begin
                    chk("resp_id", resp_valid, (q[0].id == 1) ? 2 : 1);
                    chk("resp_result", resp_result, q[0].res);
                    void'(q.pop_front());
                end
                seen = 0;
            end
        end
    end

    task automatic issue(input int id, input logic [2:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic res, input int lat, input bit track);
        int n = 0;
        exp_t e;
        req_data1[id*32 +: 32] = a;
        req_data2[id*32 +: 32] = b;
        req_op[id*3 +: 3] = op;
        req_is_signed[id] = sgn;
        req_valid[id] = 1'b1;
        #1;
        while (!req_ready[id] && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) chk("grant_timeout", 0, 1);
        else if (track) begin
            e.id = id; e.res = res; e.cyc = cyc + 1 + lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input int id, input logic [2:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic res, input int lat);
        issue(id, op, sgn, a, b, res, lat, 1);
        drain();
    endtask

    initial begin
        int n, g;
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_resp_result", resp_result, 0);
        chk("reset_cmp_data1", cmp_data1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 3'b000, 1, 16, -4, 1, 2);
        run(0, 3'b000, 0, 16, 32'hFFFFFFFC, 0, 2);
        run(1, 3'b001, 1, -16, 4, 1, 2);
        run(0, 3'b100, 1, -8, -8, 1, 3);
        run(1, 3'b101, 1, 8, -16, 1, 3);
        run(0, 3'b100, 1, 0, 0, 1, 3);
        run(1, 3'b010, 0, 3, 5, 0, 2);
        run(0, 3'b011, 0, 3, 5, 1, 2);
        run(1, 3'b101, 0, 7, 7, 0, 3);
        run(0, 3'b100, 0, 1, 2, 0, 3);
        run(1, 3'b110, 0, 9, 1, 0, 2);
        run(0, 3'b010, 1, -1, 0, 0, 2);

        // resp_ready withheld: response must hold, no new grant, other ready ignored
        resp_ready = 2'b00;
        issue(0, 3'b000, 0, 5, 3, 1, 2, 1);
        req_data1[63:32] = 1; req_data2[63:32] = 1; req_op[5:3] = 3'b100;
        req_valid[1] = 1'b1;
        n = 0;
        while (!resp_valid[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) begin
            chk("stall_resp_valid", resp_valid, 2'b01);
            chk("stall_resp_result", resp_result, 1);
            chk("stall_req_ready", req_ready, 0);
            resp_ready[1] = ~resp_ready[1];
            @(posedge clk); #1;
        end
        req_valid[1] = 1'b0;
        resp_ready = 2'b11;
        drain();

        // reset during PASS2 of an EQ, with pointer left at requester 1
        issue(0, 3'b100, 0, 5, 5, 1, 3, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_resp_valid", resp_valid, 0);
        chk("midreset_resp_result", resp_result, 0);
        chk("midreset_cmp_data2", cmp_data2, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_resp_valid", resp_valid, 0);

        // both requesters held: grants must alternate starting at 0
        req_data1 = {32'hFFFFFFF0, 32'hFFFFFFF0};
        req_data2 = {32'hFFFFFFF0, 32'hFFFFFFF0};
        req_is_signed = 2'b11;
        req_op = {3'b011, 3'b010};
        for (int i = 0; i < 4; i++) begin
            e.id = i % 2; e.res = 1'b1; e.cyc = -1;
            q.push_back(e);
        end
        req_valid = 2'b11;
        #1;
        g = 0; n = 0;
        while (g < 4 && n < 100) begin
            if (|req_ready) begin
                chk("grant_order", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
                g++;
                if (g == 4) begin
                    @(posedge clk); #1;
                    req_valid = 2'b00;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        if (g < 4) chk("alternate_grants", g, 4);
        req_valid = 2'b00;
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
